// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO port: register addresses and bus width.
package gpio_pkg;

  localparam int unsigned BUS_WIDTH = 32;

  localparam logic [2:0] GPIO_OUT     = 3'd0;
  localparam logic [2:0] GPIO_DIR     = 3'd1;
  localparam logic [2:0] GPIO_IN      = 3'd2;
  localparam logic [2:0] GPIO_IE      = 3'd3;
  localparam logic [2:0] GPIO_IS      = 3'd4;
  localparam logic [2:0] GPIO_RISE_EN = 3'd5;
  localparam logic [2:0] GPIO_FALL_EN = 3'd6;
  localparam logic [2:0] GPIO_TOGGLE  = 3'd7;

endpackage

// File: rtl/gpio_port_if.sv
// Peripheral bus seen by the GPIO port: word-addressed single-cycle read/write.
interface gpio_port_if;
  import gpio_pkg::*;

  logic [2:0]           addr;
  logic                 write;
  logic [BUS_WIDTH-1:0] writeData;
  logic                 read;
  logic [BUS_WIDTH-1:0] readData;

  modport master (output addr, output write, output writeData, output read, input readData);
  modport slave  (input addr, input write, input writeData, input read, output readData);

endinterface

// File: rtl/gpio_sync.sv
// Input synchroniser chain plus a one-edge-delayed copy for raw edge detection.
module gpio_sync #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        stage_q[s] <= '0;
      end
      prev_q <= '0;
    end else begin
      stage_q[0] <= gpio_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        stage_q[s] <= stage_q[s-1];
      end
      prev_q <= stage_q[SYNC_STAGES-1];
    end
  end

  assign sync_in = stage_q[SYNC_STAGES-1];
  assign rise    = sync_in & ~prev_q;
  assign fall    = ~sync_in & prev_q;

endmodule

// File: rtl/gpio_port.sv
// Memory-mapped GPIO port: output/direction registers, synchronised inputs with
// per-pin edge capture into W1C status bits, and a maskable level interrupt.
module gpio_port
  import gpio_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
  input  logic             clk,
  input  logic             reset,
  gpio_port_if.slave       bus,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] ie_q, ie_d;
  logic [WIDTH-1:0] is_q, is_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;

  logic [WIDTH-1:0] sync_in, rise, fall;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic [BUS_WIDTH-1:0] rdata_ext;
  logic unused_wdata;

  gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .gpio_in (gpio_in),
    .sync_in (sync_in),
    .rise    (rise),
    .fall    (fall)
  );

  assign wdata        = bus.writeData[WIDTH-1:0];
  assign unused_wdata = ^bus.writeData;

  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    ie_d      = ie_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    is_d      = is_q;
    if (bus.write) begin
      case (bus.addr)
        GPIO_OUT:     out_d     = wdata;
        GPIO_DIR:     dir_d     = wdata;
        GPIO_IE:      ie_d      = wdata;
        GPIO_IS:      is_d      = is_q & ~wdata;
        GPIO_RISE_EN: rise_en_d = wdata;
        GPIO_FALL_EN: fall_en_d = wdata;
        GPIO_TOGGLE:  out_d     = out_q ^ wdata;
        default:      ;
      endcase
    end
    // Events are applied after the W1C so a same-edge set wins over a clear.
    is_d = is_d | (rise & rise_en_q) | (fall & fall_en_q);
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      out_q     <= OUT_RESET;
      dir_q     <= '0;
      ie_q      <= '0;
      is_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      ie_q      <= ie_d;
      is_q      <= is_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.addr)
      GPIO_OUT:     rdata = out_q;
      GPIO_DIR:     rdata = dir_q;
      GPIO_IN:      rdata = sync_in;
      GPIO_IE:      rdata = ie_q;
      GPIO_IS:      rdata = is_q;
      GPIO_RISE_EN: rdata = rise_en_q;
      GPIO_FALL_EN: rdata = fall_en_q;
      default:      rdata = '0;
    endcase
  end

  always_comb begin
    rdata_ext             = '0;
    rdata_ext[WIDTH-1:0]  = rdata;
  end

  assign bus.readData = bus.read ? rdata_ext : '0;
  assign gpio_out     = out_q;
  assign gpio_oe      = dir_q;
  assign irq          = |(is_q & ie_q);

endmodule
